// File: rtl/fcs_rx_axis.sv
// ---------------------------------------------------------------------------
// fcs_rx_axis
//
// Ethernet receive FCS checker for a byte-lane AXI-Stream sink. It watches the
// de-preambled frame stream alongside the RX frame buffer and never applies
// back-pressure: every beat with s_tvalid high is consumed.
//
// CRC-32 (reflected polynomial 0xEDB88320, init all-ones, LSB first) runs over
// every byte of the frame including the trailing FCS. A good frame leaves the
// fixed residue 0xDEBB20E3 in the CRC register, so the FCS never has to be
// extracted or inverted.
//
// Per frame the block also counts bytes (saturating), checks the length
// against [MIN_LEN, MAX_LEN] and flags a PHY error reported on the tlast beat.
// All results appear as registered pulses one cycle after the tlast beat.
//
// Optional build macro: FCS_RX_STATS_EN
//   defined   : good/bad frame statistics counters with synchronous clear.
//   undefined : stat_clr is ignored and good_cnt/bad_cnt are tied to zero.
//
// Parameters
//   BYTES    datapath width in bytes (1, 2, 4 or 8)
//   MIN_LEN  minimum legal frame length in bytes, FCS included
//   MAX_LEN  maximum legal frame length in bytes, FCS included
//   LEN_W    width of the frame byte counter
//   CNT_W    width of the statistics counters
//
// Ports
//   aclk, aresetn  clock and synchronous active-low reset
//   s_tdata        frame bytes, lane 0 is the earliest byte
//   s_tkeep        byte enables, contiguous from lane 0
//   s_tvalid       beat valid
//   s_tlast        last beat of frame
//   s_tuser        PHY error, only looked at on the tlast beat
//   crc_valid      pulse: frame good
//   crc_error      pulse: CRC residue mismatch
//   len_error      pulse: length outside the legal window (or under 4 bytes)
//   phy_error      pulse: s_tuser was set on the tlast beat
//   frame_len      byte count of the last completed frame, held until the next
//   stat_clr       statistics clear
//   good_cnt       good-frame count
//   bad_cnt        bad-frame count
// ---------------------------------------------------------------------------
module fcs_rx_axis #(
  parameter int BYTES   = 1,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 16,
  parameter int CNT_W   = 32
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic [8*BYTES-1:0] s_tdata,
  input  logic [BYTES-1:0]   s_tkeep,
  input  logic               s_tvalid,
  input  logic               s_tlast,
  input  logic               s_tuser,
  output logic               crc_valid,
  output logic               crc_error,
  output logic               len_error,
  output logic               phy_error,
  output logic [LEN_W-1:0]   frame_len,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   good_cnt,
  output logic [CNT_W-1:0]   bad_cnt
);

  localparam logic [31:0]      CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0]      CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0]      CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [LEN_W-1:0] LEN_SAT     = '1;
  localparam logic [31:0]      MIN_LEN_U   = MIN_LEN;
  localparam logic [31:0]      MAX_LEN_U   = MAX_LEN;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FRAME = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             crcValid_q, crcValid_d;
  logic             crcError_q, crcError_d;
  logic             lenError_q, lenError_d;
  logic             phyError_q, phyError_d;
  logic [LEN_W-1:0] frameLen_q, frameLen_d;

  // One byte of the reflected CRC-32, LSB of the data byte first.
  function automatic logic [31:0] crcByte(input logic [31:0] crcIn,
                                          input logic [7:0]  data);
    logic [31:0] c;
    c = crcIn;
    for (int b = 0; b < 8; b++) begin
      if (c[0] ^ data[b]) begin
        c = (c >> 1) ^ CRC_POLY;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  // Fold every enabled lane of the current beat into the CRC in lane order and
  // count the enabled lanes. Disabled lanes are skipped rather than assumed to
  // be trailing, so a short non-last beat is still handled byte-wise.
  logic [31:0] crcBeat;
  logic [3:0]  keepCount;

  always_comb begin
    crcBeat   = crc_q;
    keepCount = '0;
    for (int l = 0; l < BYTES; l++) begin
      if (s_tkeep[l]) begin
        crcBeat   = crcByte(crcBeat, s_tdata[8*l +: 8]);
        keepCount = keepCount + 4'd1;
      end
    end
  end

  // Byte count including this beat; one extra bit catches the carry so the
  // counter can stick at all-ones instead of wrapping on jumbo garbage.
  logic [LEN_W:0]   lenSum;
  logic [LEN_W-1:0] lenBeat;
  logic [31:0]      lenExt;
  logic             lenOk;
  logic             residueOk;

  assign lenSum    = {1'b0, len_q} + (LEN_W+1)'(keepCount);
  assign lenBeat   = lenSum[LEN_W] ? LEN_SAT : lenSum[LEN_W-1:0];
  assign lenExt    = 32'(lenBeat);
  // Anything under 4 bytes cannot even hold an FCS, whatever MIN_LEN says.
  assign lenOk     = (lenExt >= MIN_LEN_U) && (lenExt <= MAX_LEN_U) &&
                     (lenExt >= 32'd4);
  assign residueOk = (crcBeat == CRC_RESIDUE);

  // State, CRC and length registers plus the registered result pulses.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      crc_q      <= CRC_INIT;
      len_q      <= '0;
      crcValid_q <= 1'b0;
      crcError_q <= 1'b0;
      lenError_q <= 1'b0;
      phyError_q <= 1'b0;
      frameLen_q <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      crcValid_q <= crcValid_d;
      crcError_q <= crcError_d;
      lenError_q <= lenError_d;
      phyError_q <= phyError_d;
      frameLen_q <= frameLen_d;
    end
  end

  // Next-state logic. The accumulators are reloaded on the tlast beat itself,
  // so IDLE always starts from a clean CRC/length and a new frame can begin on
  // the very next beat. A single-beat frame never leaves IDLE.
  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    len_d      = len_q;
    crcValid_d = 1'b0;
    crcError_d = 1'b0;
    lenError_d = 1'b0;
    phyError_d = 1'b0;
    frameLen_d = frameLen_q;

    case (state_q)
      IDLE: begin
        if (s_tvalid && !s_tlast) begin
          state_d = FRAME;
        end
      end
      FRAME: begin
        if (s_tvalid && s_tlast) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (s_tvalid) begin
      if (s_tlast) begin
        crc_d      = CRC_INIT;
        len_d      = '0;
        crcValid_d = residueOk && lenOk && !s_tuser;
        crcError_d = !residueOk;
        lenError_d = !lenOk;
        phyError_d = s_tuser;
        frameLen_d = lenBeat;
      end else begin
        crc_d = crcBeat;
        len_d = lenBeat;
      end
    end
  end

  assign crc_valid = crcValid_q;
  assign crc_error = crcError_q;
  assign len_error = lenError_q;
  assign phy_error = phyError_q;
  assign frame_len = frameLen_q;

`ifdef FCS_RX_STATS_EN
  logic [CNT_W-1:0] goodCnt_q, goodCnt_d;
  logic [CNT_W-1:0] badCnt_q, badCnt_d;
  logic             anyError;

  // Counters follow the result pulses. A clear landing together with a result
  // still keeps that result: the count restarts from zero plus the increment.
  always_comb begin
    anyError  = crcError_q | lenError_q | phyError_q;
    goodCnt_d = stat_clr ? '0 : goodCnt_q;
    badCnt_d  = stat_clr ? '0 : badCnt_q;
    if (crcValid_q && (goodCnt_d != '1)) begin
      goodCnt_d = goodCnt_d + CNT_W'(1);
    end
    if (anyError && (badCnt_d != '1)) begin
      badCnt_d = badCnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      goodCnt_q <= '0;
      badCnt_q  <= '0;
    end else begin
      goodCnt_q <= goodCnt_d;
      badCnt_q  <= badCnt_d;
    end
  end

  assign good_cnt = goodCnt_q;
  assign bad_cnt  = badCnt_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign good_cnt        = '0;
  assign bad_cnt         = '0;
`endif

endmodule

// File: tb/tb_fcs_rx_axis.sv
// ---------------------------------------------------------------------------
// tb_fcs_rx_axis
//
// Three checker instances (1-byte and 4-byte lanes with a 1-byte minimum
// length, 8-byte lanes with default limits) share one stimulus bus; only the
// selected instance sees s_tvalid. Every frame's expected result is queued as
// the tlast beat is driven, and a negedge monitor pops and compares whenever
// any instance pulses, including the one-cycle latency.
// ---------------------------------------------------------------------------
module tb_fcs_rx_axis;

  localparam logic [31:0] POLY    = 32'hEDB8_8320;
  localparam logic [31:0] RESIDUE = 32'hDEBB_20E3;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic [2:0]  tvalidSel;
  logic        tlast;
  logic        tuser;
  logic        statClr;

  wire [3:0]  pulse0, pulse1, pulse2;
  wire [15:0] flen0, flen1, flen2;
  wire [31:0] good0, good1, good2;
  wire [31:0] bad0, bad1, bad2;

  // Clock generation
  always #5 aclk = ~aclk;

  fcs_rx_axis #(.BYTES(1), .MIN_LEN(1)) dut1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(tdata[7:0]), .s_tkeep(tkeep[0]), .s_tvalid(tvalidSel[0]),
    .s_tlast(tlast), .s_tuser(tuser),
    .crc_valid(pulse0[3]), .crc_error(pulse0[2]), .len_error(pulse0[1]),
    .phy_error(pulse0[0]), .frame_len(flen0),
    .stat_clr(statClr), .good_cnt(good0), .bad_cnt(bad0)
  );

  fcs_rx_axis #(.BYTES(4), .MIN_LEN(1)) dut4 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(tdata[31:0]), .s_tkeep(tkeep[3:0]), .s_tvalid(tvalidSel[1]),
    .s_tlast(tlast), .s_tuser(tuser),
    .crc_valid(pulse1[3]), .crc_error(pulse1[2]), .len_error(pulse1[1]),
    .phy_error(pulse1[0]), .frame_len(flen1),
    .stat_clr(statClr), .good_cnt(good1), .bad_cnt(bad1)
  );

  fcs_rx_axis #(.BYTES(8)) dut8 (
    .aclk(aclk), .aresetn(aresetn),
    .s_tdata(tdata), .s_tkeep(tkeep), .s_tvalid(tvalidSel[2]),
    .s_tlast(tlast), .s_tuser(tuser),
    .crc_valid(pulse2[3]), .crc_error(pulse2[2]), .len_error(pulse2[1]),
    .phy_error(pulse2[0]), .frame_len(flen2),
    .stat_clr(statClr), .good_cnt(good2), .bad_cnt(bad2)
  );

  typedef struct {
    int          sel;
    logic [3:0]  flags;
    logic [15:0] len;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  frameQ[$];
  logic [31:0] crcTable[256];
  int          compareCount = 0;
  int          failCount    = 0;
  int          cycleCnt     = 0;
  int          goodModel    = 0;
  int          badModel     = 0;
  int          lastGood     = 0;
  int          lastBad      = 0;
  logic [3:0]  monP;
  logic [15:0] monLen;
  exp_t        monE;

  // Free-running cycle counter used to check result latency
  always @(posedge aclk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Table-driven reference CRC over the whole frame in frameQ
  function automatic logic [31:0] modelCrc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frameQ[i]) c = crcTable[c[7:0] ^ frameQ[i]] ^ (c >> 8);
    return c;
  endfunction

  // Random payload followed by its correct FCS, least significant byte first
  task automatic buildFrame(input int payloadLen);
    logic [31:0] fcs;
    frameQ.delete();
    for (int i = 0; i < payloadLen; i++) frameQ.push_back(8'($urandom_range(0, 255)));
    fcs = ~modelCrc();
    for (int i = 0; i < 4; i++) frameQ.push_back(fcs[8*i +: 8]);
  endtask

  task automatic pushExpected(input int sel, input bit usr, input int n);
    exp_t e;
    int   lenSat, minLen;
    bit   resOk, lenOk, cv;
    lenSat = (n > 65535) ? 65535 : n;
    minLen = (sel == 2) ? 64 : 1;
    resOk  = (modelCrc() == RESIDUE);
    lenOk  = (lenSat >= minLen) && (lenSat <= 1518) && (lenSat >= 4);
    cv     = resOk && lenOk && !usr;
    e.sel   = sel;
    e.flags = {cv, !resOk, !lenOk, usr};
    e.len   = 16'(lenSat);
    e.due   = cycleCnt + 1;
    sb.push_back(e);
    if (sel == 2) begin
      lastGood  = cv ? 1 : 0;
      lastBad   = (!resOk || !lenOk || usr) ? 1 : 0;
      goodModel += lastGood;
      badModel  += lastBad;
    end
  endtask

  // Drive frameQ to instance sel. gapEvery inserts a tvalid-low cycle after
  // that many beats; stopBeats>0 abandons the frame after that many beats;
  // emptyLast ends the frame with an extra tkeep=0 tlast beat.
  task automatic applyStimulus(input int sel, input bit usr, input int gapEvery,
                               input int stopBeats, input bit emptyLast);
    int width, n, idx, beat, nb;
    width = (sel == 0) ? 1 : (sel == 1) ? 4 : 8;
    n     = frameQ.size();
    idx   = 0;
    beat  = 0;
    while (idx < n) begin
      if (stopBeats > 0 && beat == stopBeats) return;
      nb = ((n - idx) < width) ? (n - idx) : width;
      @(posedge aclk); #1;
      tdata = {$urandom, $urandom};
      tkeep = '0;
      for (int l = 0; l < nb; l++) begin
        tdata[8*l +: 8] = frameQ[idx + l];
        tkeep[l]        = 1'b1;
      end
      idx  += nb;
      beat++;
      tlast = (idx == n) && !emptyLast;
      tuser = tlast ? usr : 1'($urandom_range(0, 1));
      tvalidSel      = '0;
      tvalidSel[sel] = 1'b1;
      if (tlast) pushExpected(sel, usr, n);
      if (gapEvery > 0 && (beat % gapEvery) == 0 && !tlast) begin
        @(posedge aclk); #1;
        tvalidSel = '0;
      end
    end
    if (emptyLast) begin
      @(posedge aclk); #1;
      tdata          = {$urandom, $urandom};
      tkeep          = '0;
      tlast          = 1'b1;
      tuser          = usr;
      tvalidSel      = '0;
      tvalidSel[sel] = 1'b1;
      pushExpected(sel, usr, n);
    end
  endtask

  // Go idle and wait (bounded) for every queued result to be seen
  task automatic drain();
    int guard;
    @(posedge aclk); #1;
    tvalidSel = '0;
    tlast     = 1'b0;
    guard     = 0;
    while (sb.size() != 0 && guard < 50) begin
      @(negedge aclk);
      guard++;
    end
    checkOutput("results drained", 32'(sb.size()), 32'd0);
  endtask

  // Result monitor: any pulse on any instance must match the queue head
  always @(negedge aclk) begin
    for (int k = 0; k < 3; k++) begin
      monP   = (k == 0) ? pulse0 : (k == 1) ? pulse1 : pulse2;
      monLen = (k == 0) ? flen0 : (k == 1) ? flen1 : flen2;
      if (monP != 4'b0000) begin
        if (sb.size() == 0) begin
          checkOutput("spurious pulse", 32'(monP), 32'd0);
        end else begin
          monE = sb.pop_front();
          checkOutput("instance", 32'(k), 32'(monE.sel));
          checkOutput("flags cv/ce/le/pe", 32'(monP), 32'(monE.flags));
          checkOutput("frame_len", 32'(monLen), 32'(monE.len));
          checkOutput("latency", 32'(cycleCnt), 32'(monE.due));
        end
      end
    end
  end

  initial begin
    logic [31:0] c;
    logic [31:0] expGood, expBad;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
      crcTable[i] = c;
    end

    aresetn   = 1'b0;
    tdata     = '0;
    tkeep     = '0;
    tvalidSel = '0;
    tlast     = 1'b0;
    tuser     = 1'b0;
    statClr   = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("reset pulses dut1", 32'(pulse0), 32'd0);
    checkOutput("reset pulses dut4", 32'(pulse1), 32'd0);
    checkOutput("reset pulses dut8", 32'(pulse2), 32'd0);
    checkOutput("reset frame_len dut1", 32'(flen0), 32'd0);
    checkOutput("reset frame_len dut4", 32'(flen1), 32'd0);
    checkOutput("reset frame_len dut8", 32'(flen2), 32'd0);
    checkOutput("reset good_cnt", good2, 32'd0);
    checkOutput("reset bad_cnt", bad2, 32'd0);

    $display("[TB] check vector 123456789 + FCS on 1- and 4-byte lanes");
    frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    applyStimulus(1, 1'b0, 0, 0, 1'b0);
    drain();
    frameQ[4] = 8'h34;
    applyStimulus(1, 1'b0, 0, 0, 1'b0);
    drain();

    $display("[TB] single-beat 4-byte frame, empty tlast beat, 3-byte runt");
    frameQ = '{8'h00, 8'h00, 8'h00, 8'h00};
    applyStimulus(1, 1'b0, 0, 0, 1'b0);
    drain();
    frameQ = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
    applyStimulus(1, 1'b0, 0, 0, 1'b1);
    drain();
    frameQ = '{8'h01, 8'h02, 8'h03};
    applyStimulus(0, 1'b0, 0, 0, 1'b0);
    drain();

    $display("[TB] 8-byte lanes: length boundaries and PHY error");
    buildFrame(60);   applyStimulus(2, 1'b0, 2, 0, 1'b0); drain();
    buildFrame(56);   applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();
    buildFrame(59);   applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();
    buildFrame(1514); applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();
    buildFrame(1515); applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();
    buildFrame(60);   applyStimulus(2, 1'b1, 0, 0, 1'b0); drain();

    $display("[TB] back-to-back frames with mid-frame tvalid gaps");
    buildFrame(60);  applyStimulus(2, 1'b0, 0, 0, 1'b0);
    buildFrame(97);  applyStimulus(2, 1'b0, 3, 0, 1'b0);
    buildFrame(9);   applyStimulus(1, 1'b0, 1, 0, 1'b0);
    buildFrame(70);  applyStimulus(2, 1'b0, 0, 0, 1'b0);
    drain();

    $display("[TB] stat_clr coincident with a good result");
    buildFrame(80);
    applyStimulus(2, 1'b0, 0, 0, 1'b0);
    @(posedge aclk); #1;
    tvalidSel = '0;
    tlast     = 1'b0;
    statClr   = 1'b1;
    @(posedge aclk); #1;
    statClr   = 1'b0;
    goodModel = lastGood;
    badModel  = lastBad;
`ifdef FCS_RX_STATS_EN
    expGood = 32'(goodModel);
`else
    expGood = 32'd0;
`endif
    checkOutput("good_cnt after clear", good2, expGood);
    drain();

    $display("[TB] reset in the middle of a frame");
    buildFrame(196);
    applyStimulus(2, 1'b0, 0, 5, 1'b0);
    @(posedge aclk); #1;
    aresetn   = 1'b0;
    tvalidSel = '0;
    repeat (2) @(posedge aclk);
    #1 aresetn = 1'b1;
    goodModel = 0;
    badModel  = 0;
    checkOutput("frame_len after reset", 32'(flen2), 32'd0);
    checkOutput("good_cnt after reset", good2, 32'd0);
    buildFrame(100); applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();

    $display("[TB] byte counter saturation");
    buildFrame(69996); applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();
    buildFrame(60);    applyStimulus(2, 1'b0, 0, 0, 1'b0); drain();

`ifdef FCS_RX_STATS_EN
    expGood = 32'(goodModel);
    expBad  = 32'(badModel);
`else
    expGood = 32'd0;
    expBad  = 32'd0;
`endif
    repeat (2) @(posedge aclk);
    #1;
    checkOutput("final good_cnt", good2, expGood);
    checkOutput("final bad_cnt", bad2, expBad);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
